// File: rtl/run_controller_if.sv
// run_controller_if: loader byte stream, ROM write port and core run-control/status signals.
interface run_controller_if #(
  parameter int ROM_AW = 8,
  parameter int CNT_W = 24
);
  logic              load_start;
  logic [ROM_AW:0]   word_count;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_byte;
  logic              rom_we;
  logic [ROM_AW-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              core_reset;
  logic              halt;
  logic [CNT_W-1:0]  timeout_limit;
  logic              busy;
  logic              done;
  logic              timed_out;
  logic [CNT_W-1:0]  cycle_count;
  logic              ram_debug_en;
  modport master (
    input  load_start, word_count, abort, in_valid, in_byte, halt, timeout_limit,
    output in_ready, rom_we, rom_waddr, rom_wdata, core_reset, busy, done, timed_out,
           cycle_count, ram_debug_en
  );
  modport slave (
    output load_start, word_count, abort, in_valid, in_byte, halt, timeout_limit,
    input  in_ready, rom_we, rom_waddr, rom_wdata, core_reset, busy, done, timed_out,
           cycle_count, ram_debug_en
  );
endinterface

// File: rtl/run_controller.sv
// run_controller: streams a program into ROM, holds the core in reset, runs it to halt/timeout.
module run_controller #(
  parameter int ROM_AW = 8,
  parameter int RESET_CYCLES = 3,
  parameter int CNT_W = 24
) (
  input logic clk,
  input logic reset,
  run_controller_if.master bus
);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [ROM_AW:0] count, wc_clip;
  logic [ROM_AW-1:0] widx;
  logic [1:0] bidx;
  logic [HW-1:0] hold_cnt;
  logic [CNT_W-1:0] limit, cyc, cyc_n;
  logic [31:0] wdata;
  logic we, armed, done_q, tout, accept, last_word, halted, hit;
  assign wc_clip = bus.word_count[ROM_AW] ? {1'b1, {ROM_AW{1'b0}}} : bus.word_count;
  assign accept = bus.in_valid && state == LOAD && !we;
  assign last_word = {1'b0, widx} == count - 1'b1;
  assign cyc_n = &cyc ? cyc : cyc + 1'b1;
  assign halted = armed && bus.halt;
  // the run cycle that brings the count to the limit is the last one
  assign hit = limit != '0 && cyc_n == limit;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (bus.load_start) state_n = wc_clip != '0 ? LOAD : HOLD;
      LOAD: if (we && last_word) state_n = HOLD;
      HOLD: if (hold_cnt == HW'(RESET_CYCLES - 1)) state_n = RUN;
      RUN: if (halted || hit) state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (bus.abort) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      we <= 1'b0;
      widx <= '0;
      wdata <= '0;
      bidx <= '0;
      count <= '0;
      hold_cnt <= '0;
      limit <= '0;
      cyc <= '0;
      armed <= 1'b0;
      done_q <= 1'b0;
      tout <= 1'b0;
    end else begin
      we <= state_n == LOAD && accept && bidx == 2'd3;
      done_q <= state == RUN && state_n == DONE;
      hold_cnt <= state == HOLD ? hold_cnt + 1'b1 : '0;
      if (state != LOAD && state_n == LOAD) begin
        count <= wc_clip;
        widx <= '0;
        bidx <= '0;
      end
      if (accept && state_n == LOAD) begin
        wdata[8*bidx +: 8] <= bus.in_byte;
        bidx <= bidx + 1'b1;
      end
      if (we) widx <= widx + 1'b1;
      if (state == HOLD && !bus.abort) begin
        cyc <= '0;
        tout <= 1'b0;
        armed <= 1'b0;
        limit <= bus.timeout_limit;
      end
      if (state == RUN && !bus.abort) begin
        cyc <= cyc_n;
        armed <= armed || !bus.halt;
        tout <= hit && !halted;
      end
    end
  end
  assign bus.in_ready = state == LOAD && !we;
  assign bus.rom_we = we;
  assign bus.rom_waddr = widx;
  assign bus.rom_wdata = wdata;
  assign bus.core_reset = state == IDLE || state == LOAD || state == HOLD;
  assign bus.busy = state == LOAD || state == HOLD || state == RUN;
  assign bus.done = done_q;
  assign bus.timed_out = tout;
  assign bus.cycle_count = cyc;
  assign bus.ram_debug_en = state == DONE;
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed and randomized load/run sequences checked against a behavioural model.
module tb_run_controller;
  localparam int RC = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int hold_n = 0;
  logic [7:0] bq[$];
  bit hq[$];
  logic [7:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] rom_mem [0:255];
  logic [31:0] exp_rom [0:255];
  run_controller_if #(.ROM_AW(8), .CNT_W(24)) bus ();
  run_controller #(.ROM_AW(8), .RESET_CYCLES(RC), .CNT_W(24)) dut (.clk(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.rom_we) begin
      wa.push_back(bus.rom_waddr);
      wd.push_back(bus.rom_wdata);
      rom_mem[bus.rom_waddr] = bus.rom_wdata;
      chk("ready_on_write", {31'd0, bus.in_ready}, 0);
    end
    if (bus.busy && bus.core_reset && !bus.in_ready && !bus.rom_we) hold_n++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_check(input string t);
    chk({t, "_core_reset"}, {31'd0, bus.core_reset}, 1);
    chk({t, "_in_ready"}, {31'd0, bus.in_ready}, 0);
    chk({t, "_rom_we"}, {31'd0, bus.rom_we}, 0);
    chk({t, "_rom_waddr"}, {24'd0, bus.rom_waddr}, 0);
    chk({t, "_rom_wdata"}, bus.rom_wdata, 0);
    chk({t, "_busy"}, {31'd0, bus.busy}, 0);
    chk({t, "_done"}, {31'd0, bus.done}, 0);
    chk({t, "_timed_out"}, {31'd0, bus.timed_out}, 0);
    chk({t, "_cycle_count"}, {8'd0, bus.cycle_count}, 0);
    chk({t, "_ram_debug_en"}, {31'd0, bus.ram_debug_en}, 0);
  endtask
  function automatic logic [31:0] word_of(input int i);
    return 32'(bq[4*i]) + (32'(bq[4*i+1]) << 8) + (32'(bq[4*i+2]) << 16) + (32'(bq[4*i+3]) << 24);
  endfunction
  // stop_after > 0 stops feeding after that many accepted bytes and leaves the load in progress
  task automatic load(input int wc, input bit cont, input int stop_after);
    int n, nacc, guard;
    bit acc;
    n = wc > 256 ? 256 : wc;
    nacc = 0;
    guard = 0;
    hold_n = 0;
    wa.delete();
    wd.delete();
    bus.word_count = 9'(wc);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    while (!(bus.busy && bus.core_reset && !bus.in_ready && !bus.rom_we) &&
           (stop_after == 0 || nacc < stop_after) && guard < 6000) begin
      bus.in_valid = cont ? 1'b1 : 1'($urandom_range(0, 1));
      bus.in_byte = nacc < bq.size() ? bq[nacc] : 8'h00;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) nacc++;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("load_bound", guard, guard < 6000 ? guard : 0);
    if (stop_after == 0) begin
      chk("load_bytes", nacc, 4 * n);
      chk("load_writes", wa.size(), n);
      for (int i = 0; i < wa.size() && i < n; i++) begin
        chk("write_addr", {24'd0, wa[i]}, i);
        chk("write_data", wd[i], word_of(i));
        exp_rom[i] = word_of(i);
      end
    end
  endtask
  task automatic run_check(input int lim);
    int ek, k, guard;
    bit eto, armed, h;
    armed = 0;
    eto = 0;
    ek = 0;
    for (int j = 1; j < 5000; j++) begin
      h = j <= hq.size() ? hq[j-1] : 1'b0;
      if (armed && h) begin ek = j; eto = 0; break; end
      if (lim != 0 && j == lim) begin ek = j; eto = 1; break; end
      if (!h) armed = 1;
    end
    k = 0;
    guard = 0;
    while (!bus.ram_debug_en && guard < 5000) begin
      if (bus.busy && !bus.core_reset) begin
        k++;
        bus.halt = k <= hq.size() ? hq[k-1] : 1'b0;
        bus.word_count = '0;
        bus.load_start = k == 2;
      end else bus.halt = 1'b1;
      tick();
      bus.load_start = 1'b0;
      guard++;
    end
    chk("run_bound", guard, guard < 5000 ? guard : 0);
    chk("hold_cycles", hold_n, RC);
    chk("run_cycles", k, ek);
    chk("done_first", {31'd0, bus.done}, 1);
    chk("dbg_en_first", {31'd0, bus.ram_debug_en}, 1);
    chk("busy_done", {31'd0, bus.busy}, 0);
    chk("core_reset_done", {31'd0, bus.core_reset}, 0);
    chk("cycle_count", {8'd0, bus.cycle_count}, ek);
    chk("timed_out", {31'd0, bus.timed_out}, {31'd0, eto});
    bus.halt = 1'b1;
    tick();
    chk("done_second", {31'd0, bus.done}, 0);
    chk("dbg_en_second", {31'd0, bus.ram_debug_en}, 1);
    chk("cycle_count_hold", {8'd0, bus.cycle_count}, ek);
    chk("timed_out_hold", {31'd0, bus.timed_out}, {31'd0, eto});
  endtask
  initial begin
    int lim, guard;
    bus.load_start = 1'b0;
    bus.word_count = '0;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte = '0;
    bus.halt = 1'b1;
    bus.timeout_limit = '0;
    tick();
    tick();
    reset_check("rst");
    rst = 1'b0;
    tick();
    // the two-instruction program, then halt after four quiet run cycles
    bq = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
    load(2, 1'b0, 0);
    chk("prog_word0", exp_rom[0], 32'h00100013);
    chk("prog_word1", exp_rom[1], 32'h00100073);
    hq = '{0, 0, 0, 0, 1};
    run_check(0);
    bus.timeout_limit = 24'd10;
    hq.delete();
    load(0, 1'b0, 0);
    run_check(10);
    bus.timeout_limit = 24'd7;
    hq = '{0, 0, 0, 0, 0, 0, 1};
    load(0, 1'b0, 0);
    run_check(7);
    // continuous valid: only four bytes per word may be taken
    bq.delete();
    repeat (12) bq.push_back(8'($urandom));
    bus.timeout_limit = 24'd0;
    hq = '{0, 0, 1};
    load(3, 1'b1, 0);
    run_check(0);
    bq.delete();
    repeat (12) bq.push_back(8'($urandom));
    load(3, 1'b0, 6);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 0);
    chk("abort_core_reset", {31'd0, bus.core_reset}, 1);
    chk("abort_in_ready", {31'd0, bus.in_ready}, 0);
    bus.in_valid = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    chk("abort_writes", wa.size(), 1);
    exp_rom[0] = word_of(0);
    bus.timeout_limit = 24'd4;
    hq.delete();
    load(0, 1'b0, 0);
    for (int i = 0; i < 3; i++) chk("rom_image", rom_mem[i], exp_rom[i]);
    run_check(4);
    bq.delete();
    repeat (1024) bq.push_back(8'($urandom));
    bus.timeout_limit = 24'd0;
    hq = '{0, 1};
    load(261, 1'b1, 0);
    run_check(0);
    for (int it = 0; it < 4; it++) begin
      bq.delete();
      repeat (16) bq.push_back(8'($urandom));
      lim = $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 25));
      bus.timeout_limit = 24'(lim);
      hq.delete();
      repeat ($urandom_range(0, 15)) hq.push_back(1'($urandom_range(0, 1)));
      hq.push_back(1'b0);
      hq.push_back(1'b1);
      load(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 0);
      run_check(lim);
    end
    bus.timeout_limit = 24'd0;
    bus.halt = 1'b1;
    bus.word_count = '0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    guard = 0;
    while (!(bus.busy && !bus.core_reset) && guard < 20) begin
      tick();
      guard++;
    end
    chk("reach_run", guard, guard < 20 ? guard : 0);
    bus.halt = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    reset_check("rst_run");
    rst = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
